// File: rtl/wes207_spi_regbank.sv
// SPI slave (mode 0, 16-bit frames) fronting a small register bank with GPO,
// LED control and a heartbeat counter; everything runs on pll_clk.
module wes207_spi_regbank #(
  parameter int GPO_WIDTH   = 7,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BLINK_BITS  = 24
) (
  input  logic                 pll_clk,
  input  logic                 reset,
  input  logic                 SCLK,
  input  logic                 SSB,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [GPO_WIDTH-1:0] gpo_pins,
  output logic                 led0,
  output logic                 led1,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] GPO_MASK = 8'((1 << GPO_WIDTH) - 1);
  localparam logic [7:0] LED_MASK = 8'h07;
  localparam logic [7:0] ID_VAL   = 8'hA5;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_s, ssb_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ssb_rise, ssb_fall, mosi_bit;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt;
  logic [6:0]  sh;
  logic        is_wr;
  logic [6:0]  addr_q;
  logic [7:0]  shout;
  logic [7:0]  regs [NUM_REGS];
  logic [BLINK_BITS-1:0] hb;

  logic        cmd_done, wr_commit;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data, wr_val, wr_mask;

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      sclk_s <= '0;
      ssb_s  <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], SCLK};
      ssb_s  <= {ssb_s[SYNC_STAGES-2:0], SSB};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign sclk_rise = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
  assign ssb_rise  = ssb_s[SYNC_STAGES-2] & ~ssb_s[SYNC_STAGES-1];
  assign ssb_fall  = ~ssb_s[SYNC_STAGES-2] & ssb_s[SYNC_STAGES-1];
  // MOSI is launched on the previous SCLK fall, so the one-cycle-older stage
  // is still stable at the detected rise.
  assign mosi_bit  = mosi_s[SYNC_STAGES-1];

  always_ff @(posedge pll_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      IDLE: if (ssb_fall) state_d = CMD;
      CMD: begin
        if (ssb_rise) state_d = IDLE;
        else if (sclk_rise && bit_cnt == 4'd7) begin
          state_d  = DATA;
          cmd_done = 1'b1;
        end
      end
      DATA: begin
        if (ssb_rise) state_d = IDLE;
        else if (sclk_rise && bit_cnt == 4'd15) begin
          state_d   = DONE;
          wr_commit = is_wr;
        end
      end
      DONE: if (ssb_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr = {sh[5:0], mosi_bit};
  assign wr_val  = {sh, mosi_bit};

  always_comb begin
    rd_data = 8'h00;
    if (int'(rd_addr) < NUM_REGS)
      rd_data = (rd_addr == 7'd0) ? ID_VAL : regs[rd_addr[AW-1:0]];
  end

  always_comb begin
    case (addr_q)
      7'd1:    wr_mask = GPO_MASK;
      7'd2:    wr_mask = LED_MASK;
      default: wr_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      bit_cnt <= '0;
      sh      <= '0;
      is_wr   <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (state_q == IDLE) bit_cnt <= '0;
      else if ((state_q == CMD || state_q == DATA) && sclk_rise) begin
        bit_cnt <= bit_cnt + 4'd1;
        sh      <= {sh[5:0], mosi_bit};
      end
      if (cmd_done) begin
        is_wr  <= sh[6];
        addr_q <= rd_addr;
      end
    end
  end

  // Shift-out only advances on falls seen inside DATA of a read frame.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      MISO  <= 1'b0;
      shout <= '0;
    end else if (cmd_done) begin
      shout <= sh[6] ? 8'h00 : rd_data;
      MISO  <= 1'b0;
    end else if (state_d != DATA) begin
      MISO  <= 1'b0;
    end else if (state_q == DATA && !is_wr && sclk_fall) begin
      MISO  <= shout[7];
      shout <= {shout[6:0], 1'b0};
    end
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= wr_commit;
      if (wr_commit) begin
        wr_addr <= addr_q;
        wr_data <= wr_val;
        if (int'(addr_q) < NUM_REGS && addr_q != 7'd0)
          regs[addr_q[AW-1:0]] <= wr_val & wr_mask;
      end
    end
  end

  always_ff @(posedge pll_clk) begin
    if (reset) hb <= '0;
    else       hb <= hb + 1'b1;
  end

  assign gpo_pins = regs[1][GPO_WIDTH-1:0];
  assign led0     = regs[2][0];
  assign led1     = regs[2][2] ? hb[BLINK_BITS-1] : regs[2][1];

endmodule

// File: tb/tb_wes207_spi_regbank.sv
// Directed + randomized frames against a register-map model of the SPI bank.
module tb_wes207_spi_regbank;

  localparam int GPO_WIDTH = 7;
  localparam int NUM_REGS  = 8;
  localparam int HALF      = 6;

  logic                 pll_clk = 1'b0;
  logic                 reset, SCLK, SSB, MOSI;
  logic                 MISO, led0, led1, wr_strobe;
  logic [GPO_WIDTH-1:0] gpo_pins;
  logic [6:0]           wr_addr;
  logic [7:0]           wr_data;

  int n_chk  = 0;
  int n_fail = 0;
  int scnt   = 0;

  logic [7:0] mdl [NUM_REGS];

  wes207_spi_regbank #(
    .GPO_WIDTH(GPO_WIDTH), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2), .BLINK_BITS(4)
  ) dut (
    .pll_clk(pll_clk), .reset(reset), .SCLK(SCLK), .SSB(SSB), .MOSI(MOSI),
    .MISO(MISO), .gpo_pins(gpo_pins), .led0(led0), .led1(led1),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 pll_clk = ~pll_clk;

  always @(negedge pll_clk) if (wr_strobe === 1'b1) scnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pll_clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 8'h00;
  endfunction

  function automatic void m_write(input int a, input logic [7:0] d);
    if (a >= NUM_REGS || a == 0) return;
    if (a == 1)      mdl[a] = d & 8'h7F;
    else if (a == 2) mdl[a] = d & 8'h07;
    else             mdl[a] = d;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a >= NUM_REGS) return 8'h00;
    if (a == 0)        return 8'hA5;
    return mdl[a];
  endfunction

  task automatic spi_frame(input logic [15:0] f, input int nbits,
                           output logic [7:0] rd, output logic miso_seen);
    rd = 8'h00;
    miso_seen = 1'b0;
    SSB = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[15-i];
      tick(HALF);
      miso_seen |= MISO;
      if (i >= 8) rd[15-i] = MISO;
      SCLK = 1'b1;
      tick(HALF);
      miso_seen |= MISO;
      SCLK = 1'b0;
    end
    tick(HALF);
    miso_seen |= MISO;
    SSB = 1'b1;
    tick(HALF);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic       ms;
    int         s0;
    s0 = scnt;
    spi_frame({1'b1, a, d}, 16, rd, ms);
    m_write(int'(a), d);
    chk("wr_strobe_pulses", 32'(scnt - s0), 32'd1);
    chk("wr_addr", 32'(wr_addr), 32'(a));
    chk("wr_data", 32'(wr_data), 32'(d));
    chk("miso_quiet_on_write", 32'(ms), 32'd0);
    chk("gpo_pins", 32'(gpo_pins), 32'(mdl[1][GPO_WIDTH-1:0]));
    chk("led0", 32'(led0), 32'(mdl[2][0]));
  endtask

  task automatic do_read(input logic [6:0] a);
    logic [7:0] rd, exp;
    logic       ms;
    int         s0;
    s0 = scnt;
    spi_frame({1'b0, a, 8'h00}, 16, rd, ms);
    exp = m_read(int'(a));
    chk($sformatf("read_%0h", a), 32'(rd), 32'(exp));
    chk("no_strobe_on_read", 32'(scnt - s0), 32'd0);
  endtask

  initial begin
    logic [7:0] rd, idv;
    logic       ms, v, found;
    int         s0;

    reset = 1'b1; SSB = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    m_reset();
    tick(4);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_gpo", 32'(gpo_pins), 32'd0);
    chk("rst_led0", 32'(led0), 32'd0);
    chk("rst_led1", 32'(led1), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    tick(4);

    do_write(7'h01, 8'h5A);
    chk("gpo_5a", 32'(gpo_pins), 32'h5A);
    do_read(7'h00);

    // Heartbeat blink on led1 with LEDCTL[2] set.
    do_write(7'h02, 8'h04);
    chk("led0_off", 32'(led0), 32'd0);
    v = led1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick(1);
      if (led1 !== v) found = 1'b1;
    end
    chk("led1_edge_found", 32'(found), 32'd1);
    v = led1;
    for (int n = 1; n <= 32; n++) begin
      tick(1);
      chk($sformatf("led1_blink_%0d", n), 32'(led1), 32'(v ^ ((n / 8) % 2 == 1)));
    end
    chk("led0_still_off", 32'(led0), 32'd0);

    // Aborted write after 12 bits.
    s0 = scnt;
    spi_frame(16'h83C3, 12, rd, ms);
    chk("abort_no_strobe", 32'(scnt - s0), 32'd0);
    do_read(7'h03);

    // Out-of-range write must not disturb scratch.
    do_write(7'h04, 8'h3C);
    do_write(7'h07, 8'hE1);
    do_write(7'h7F, 8'h11);
    do_read(7'h7F);
    for (int a = 3; a < NUM_REGS; a++) do_read(7'(a));

    // Reset during the DATA phase of a read of ID.
    SSB = 1'b0; MOSI = 1'b0;
    tick(HALF);
    for (int i = 0; i < 10; i++) begin
      tick(HALF); SCLK = 1'b1;
      tick(HALF); SCLK = 1'b0;
    end
    tick(HALF);
    idv = m_read(0);
    chk("miso_before_reset", 32'(MISO), 32'(idv[5]));
    reset = 1'b1;
    tick(1);
    chk("miso_in_reset", 32'(MISO), 32'd0);
    SSB = 1'b1;
    tick(3);
    reset = 1'b0;
    m_reset();
    tick(4);
    chk("wr_addr_after_reset", 32'(wr_addr), 32'd0);
    do_read(7'h00);
    do_read(7'h04);
    do_write(7'h05, 8'h96);
    do_read(7'h05);

    // Randomized traffic, each write immediately followed by a readback.
    for (int k = 0; k < 30; k++) begin
      logic [6:0] a;
      logic [7:0] d;
      a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 11));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d);
        if (mdl[2][2] == 1'b0) chk("led1_static", 32'(led1), 32'(mdl[2][1]));
      end
      do_read(a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wes207_spi_regbank.md
WES207_SPI_REGBANK -- requirements
Module: wes207_spi_regbank

Interface
REQ-001 Parameter GPO_WIDTH, default 7: gpo_pins width, legal range 1..8.
REQ-002 Parameter NUM_REGS, default 8: implemented registers, power of 2, legal range 4..128.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops on SCLK, SSB and MOSI, minimum 2.
REQ-004 Parameter BLINK_BITS, default 24: heartbeat counter width.
REQ-005 Port pll_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port SCLK, input, 1 bit: SPI clock, asynchronous, oversampled by pll_clk.
REQ-008 Port SSB, input, 1 bit: SPI chip select, active low, asynchronous.
REQ-009 Port MOSI, input, 1 bit: SPI serial data in, asynchronous.
REQ-010 Port MISO, output, 1 bit: SPI serial data out, always driven, never tristated.
REQ-011 Port gpo_pins, output, GPO_WIDTH bits: general-purpose outputs.
REQ-012 Port led0, output, 1 bit: LED drive.
REQ-013 Port led1, output, 1 bit: LED drive.
REQ-014 Port wr_strobe, output, 1 bit: one-cycle pulse on every accepted write.
REQ-015 Port wr_addr, output, 7 bits: address of the last accepted write.
REQ-016 Port wr_data, output, 8 bits: data of the last accepted write.

Function
REQ-017 The SPI link SHALL be mode 0, MSB first, with 16-bit frames laid out as follows.
- bit15: 1 = write, 0 = read.
- bits14:8: address.
- bits7:0: write data (don't-care on reads).
REQ-018 The block SHALL detect SCLK edges and SSB edges from the last two synchroniser stages; SCLK high and low times are each at least 4 pll_clk periods.
REQ-019 The FSM SHALL have states IDLE, CMD, DATA and DONE.
- IDLE -> CMD on SSB falling.
- CMD -> DATA after the 8th SCLK rise.
- DATA -> DONE after the 16th SCLK rise.
- DONE -> IDLE on SSB rising.
REQ-020 SSB rising in CMD or DATA SHALL abort the frame: return to IDLE, no write, no register change.
REQ-021 In DONE, further SCLK edges SHALL be ignored; MISO SHALL be 0.
REQ-022 At the 8th SCLK rise of a read, the block SHALL capture register[addr] into an 8-bit shift-out register.
REQ-023 On a read, MISO SHALL present the shift-out bits 7..0, changing on each synchronised SCLK fall from the 8th through the 15th.
REQ-024 MISO SHALL be 0 in IDLE, CMD, DONE, and for the whole of every write frame.
REQ-025 A write SHALL commit exactly 1 pll_clk cycle after the synchronised 16th SCLK rise.
- wr_strobe = 1 for that one cycle.
- wr_addr and wr_data are updated in the same cycle.
- The target register and its derived outputs update in the same cycle.
REQ-026 Register map:
- 0x00: ID, read-only, 0xA5; writes are ignored but still strobe.
- 0x01: GPO; gpo_pins = reg[GPO_WIDTH-1:0]; unused bits read back 0.
- 0x02: LEDCTL, bits[2:0] R/W; bits7:3 read 0.
- 0x03..NUM_REGS-1: scratch, 8-bit R/W.
REQ-027 A write to address >= NUM_REGS SHALL change no register, SHALL still pulse wr_strobe, and a read from such an address SHALL return 0x00.
REQ-028 LED outputs SHALL be derived from LEDCTL:
- led0 = LEDCTL[0].
- led1 = LEDCTL[2] ? hb[BLINK_BITS-1] : LEDCTL[1].
REQ-029 hb SHALL be a free-running BLINK_BITS-bit counter that increments every cycle and wraps to 0.
REQ-030 A write and a read to the same address in back-to-back frames SHALL return the newly written value.

Reset
REQ-031 With reset high, the block SHALL enter IDLE and drive: MISO=0, gpo_pins=0, led0=0, led1=0, wr_strobe=0, wr_addr=0, wr_data=0, hb=0, all R/W registers=0x00, synchronisers=SSB high / SCLK low.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after reset releases, the FSM waits for a fresh SSB falling edge.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Write 0x81_5A -> wr_strobe pulse, wr_addr=0x01, wr_data=0x5A, gpo_pins=0x5A (GPO_WIDTH=7).
- Read 0x00_00 -> MISO bits on the last 8 SCLKs = 0xA5.
- Write 0x82_04, then run 2^BLINK_BITS cycles (BLINK_BITS=4 in the bench) -> led1 toggles every 8 cycles; led0=0.
- Write 0x83_C3, with SSB raised after 12 bits -> no wr_strobe; a subsequent read of 0x03 returns 0x00.
- Write 0xFF_11 at NUM_REGS=8 -> wr_strobe=1, wr_addr=0x7F; a read of 0x7F returns 0x00; scratch registers are unchanged.
- Reset pulsed during the DATA phase of a read -> MISO=0 immediately; the next full frame works normally.
